// File: rtl/char_jump_ctrl.sv
// Character jump controller: ground/rise/fall physics with air steering.
// Ports: clk_40MHz, rst (sync, active-high), movement_tick (physics strobe),
//   jump_req (level), dir_left/dir_right (air steering) -> xpos/ypos (12b),
//   airborne (RISE or FALL), landed (1-cycle touchdown pulse).
// Latency: 1 cycle from a tick to the visible update. No backpressure; outputs hold between ticks.
module char_jump_ctrl #(
  parameter logic [11:0] X_START  = 12'd380,
  parameter logic [11:0] Y_GROUND = 12'd500,
  parameter logic [5:0]  JUMP_V0  = 6'd12,
  parameter logic [5:0]  V_MAX    = 6'd16,
  parameter logic [3:0]  GRAV_DIV = 4'd8,
  parameter logic [11:0] X_MAX    = 12'd760
) (
  input  logic        clk_40MHz,
  input  logic        rst,
  input  logic        movement_tick,
  input  logic        jump_req,
  input  logic        dir_left,
  input  logic        dir_right,
  output logic [11:0] xpos,
  output logic [11:0] ypos,
  output logic        airborne,
  output logic        landed
);

  typedef enum logic [1:0] {GROUND = 2'd0, RISE = 2'd1, FALL = 2'd2} state_t;

  localparam logic [3:0] GRAV_LAST = GRAV_DIV - 4'd1;

  state_t      state_q, state_d;
  logic [11:0] xpos_q, xpos_d;
  logic [11:0] ypos_q, ypos_d;
  logic [5:0]  vel_q, vel_d;
  logic [3:0]  grav_cnt_q, grav_cnt_d;
  logic        pending_q, pending_d;
  logic        landed_q, landed_d;
  logic        jump_req_q;

  // Vertical math is done one bit wider so ypos+vel never wraps.
  logic [12:0] y_wide, vel_wide, y_sum;
  logic        hit_ceiling, hit_ground, grav_wrap, jump_edge;
  logic [3:0]  grav_next;
  logic [11:0] xpos_steer;

  assign y_wide      = {1'b0, ypos_q};
  assign vel_wide    = {7'b0, vel_q};
  assign y_sum       = y_wide + vel_wide;
  assign hit_ceiling = (vel_wide >= y_wide);
  assign hit_ground  = (y_sum >= {1'b0, Y_GROUND});
  assign grav_wrap   = (grav_cnt_q == GRAV_LAST);
  assign grav_next   = grav_wrap ? 4'd0 : grav_cnt_q + 4'd1;
  assign jump_edge   = jump_req & ~jump_req_q;

  // Steering: exactly one direction moves, both or neither holds.
  always_comb begin
    xpos_steer = xpos_q;
    if (dir_left && !dir_right) begin
      xpos_steer = (xpos_q == 12'd0) ? 12'd0 : xpos_q - 12'd1;
    end else if (dir_right && !dir_left) begin
      xpos_steer = (xpos_q >= X_MAX) ? X_MAX : xpos_q + 12'd1;
    end
  end

  // State register (all sequential state lives here).
  always_ff @(posedge clk_40MHz) begin
    if (rst) begin
      state_q    <= GROUND;
      xpos_q     <= X_START;
      ypos_q     <= Y_GROUND;
      vel_q      <= 6'd0;
      grav_cnt_q <= 4'd0;
      pending_q  <= 1'b0;
      landed_q   <= 1'b0;
      jump_req_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      xpos_q     <= xpos_d;
      ypos_q     <= ypos_d;
      vel_q      <= vel_d;
      grav_cnt_q <= grav_cnt_d;
      pending_q  <= pending_d;
      landed_q   <= landed_d;
      jump_req_q <= jump_req;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (movement_tick) begin
      case (state_q)
        GROUND:  if (pending_q) state_d = RISE;
        // Apex: ceiling clamp, or the velocity about to decay to zero.
        RISE:    if (hit_ceiling || vel_q == 6'd0 || (grav_wrap && vel_q == 6'd1)) state_d = FALL;
        FALL:    if (hit_ground) state_d = GROUND;
        default: state_d = GROUND;
      endcase
    end
  end

  // Datapath next values.
  always_comb begin
    xpos_d     = xpos_q;
    ypos_d     = ypos_q;
    vel_d      = vel_q;
    grav_cnt_d = grav_cnt_q;
    pending_d  = pending_q;
    landed_d   = 1'b0;
    if (state_q == GROUND) begin
      // Launch tick consumes the request; ypos stays put until the first rise tick.
      if (movement_tick && pending_q) begin
        vel_d      = JUMP_V0;
        grav_cnt_d = 4'd0;
        pending_d  = 1'b0;
      end else if (jump_edge) begin
        pending_d = 1'b1;
      end
    end else if (movement_tick) begin
      xpos_d     = xpos_steer;
      grav_cnt_d = grav_next;
      if (state_q == RISE) begin
        if (hit_ceiling) begin
          ypos_d = 12'd0;
          vel_d  = 6'd0;
        end else begin
          ypos_d = ypos_q - {6'b0, vel_q};
          if (grav_wrap && vel_q != 6'd0) vel_d = vel_q - 6'd1;
        end
      end else begin
        if (hit_ground) begin
          ypos_d     = Y_GROUND;
          vel_d      = 6'd0;
          grav_cnt_d = 4'd0;
          landed_d   = 1'b1;
        end else begin
          ypos_d = y_sum[11:0];
          if (grav_wrap && vel_q < V_MAX) vel_d = vel_q + 6'd1;
        end
      end
    end
  end

  // Outputs, all from registered state.
  always_comb begin
    xpos     = xpos_q;
    ypos     = ypos_q;
    airborne = (state_q != GROUND);
    landed   = landed_q;
  end

endmodule

// File: tb/tb_char_jump_ctrl.sv
// Testbench for char_jump_ctrl: two instances (default, and low-ceiling/right-edge) share stimulus.
// A reference model predicts each cycle's outputs into per-DUT queues, popped after the clock edge.
// Directed scenarios: basic jump, ceiling, steering limits, request filtering, tick gating, reset.
module tb_char_jump_ctrl;
  localparam int V0 = 12, VMAX = 16, GD = 8, XMAX = 760;

  logic clk_40MHz = 1'b0;
  logic rst, movement_tick, jump_req, dir_left, dir_right;
  logic [11:0] xpos, ypos, c_xpos, c_ypos;
  logic airborne, landed, c_airborne, c_landed;

  int n_tests = 0;
  int n_fail  = 0;

  always #12 clk_40MHz = ~clk_40MHz;

  char_jump_ctrl dut (
    .clk_40MHz(clk_40MHz), .rst(rst), .movement_tick(movement_tick), .jump_req(jump_req),
    .dir_left(dir_left), .dir_right(dir_right),
    .xpos(xpos), .ypos(ypos), .airborne(airborne), .landed(landed)
  );

  char_jump_ctrl #(.X_START(12'd759), .Y_GROUND(12'd20)) dut_c (
    .clk_40MHz(clk_40MHz), .rst(rst), .movement_tick(movement_tick), .jump_req(jump_req),
    .dir_left(dir_left), .dir_right(dir_right),
    .xpos(c_xpos), .ypos(c_ypos), .airborne(c_airborne), .landed(c_landed)
  );

  typedef struct {
    int st;   // 0 ground, 1 rise, 2 fall
    int x;
    int y;
    int vel;
    int cnt;
    bit pend;
    bit jr;
    bit land;
  } mdl_t;

  typedef struct {
    int x;
    int y;
    bit air;
    bit land;
  } exp_t;

  mdl_t m0, m1, snap;
  exp_t q0[$], q1[$];

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic mdl_t mstep(mdl_t m, int yg, int xs, bit r, bit tk, bit jr, bit l, bit rt);
    mdl_t n;
    bit   edge_seen;
    bit   launch;
    bit   wrap;
    n = m;
    if (r) begin
      n.st = 0; n.x = xs; n.y = yg; n.vel = 0; n.cnt = 0;
      n.pend = 0; n.jr = 0; n.land = 0;
      return n;
    end
    edge_seen = jr && !m.jr;
    n.jr   = jr;
    n.land = 0;
    launch = 0;
    if (tk) begin
      if (m.st == 0) begin
        if (m.pend) begin
          n.st = 1; n.vel = V0; n.cnt = 0; n.pend = 0; launch = 1;
        end
      end else begin
        wrap  = (m.cnt == GD - 1);
        n.cnt = wrap ? 0 : m.cnt + 1;
        if (m.st == 1) begin
          if (m.vel >= m.y) begin
            n.y = 0; n.vel = 0; n.st = 2;
          end else begin
            n.y = m.y - m.vel;
            if (wrap) n.vel = m.vel - 1;
            if (n.vel == 0) n.st = 2;
          end
        end else begin
          if (m.y + m.vel >= yg) begin
            n.y = yg; n.vel = 0; n.st = 0; n.land = 1; n.cnt = 0;
          end else begin
            n.y = m.y + m.vel;
            if (wrap && m.vel < VMAX) n.vel = m.vel + 1;
          end
        end
        if (l && !rt)      n.x = (m.x > 0) ? m.x - 1 : 0;
        else if (rt && !l) n.x = (m.x < XMAX) ? m.x + 1 : XMAX;
      end
    end
    if (m.st == 0 && !launch && edge_seen) n.pend = 1;
    return n;
  endfunction

  function automatic exp_t expect_of(mdl_t m);
    exp_t e;
    e.x = m.x; e.y = m.y; e.air = (m.st != 0); e.land = m.land;
    return e;
  endfunction

  // One clock: drive inputs, predict, then compare both DUTs after the edge.
  task automatic cyc(input bit r, input bit tk, input bit jr, input bit l, input bit rt);
    exp_t e;
    rst = r; movement_tick = tk; jump_req = jr; dir_left = l; dir_right = rt;
    m0 = mstep(m0, 500, 380, r, tk, jr, l, rt);
    m1 = mstep(m1, 20, 759, r, tk, jr, l, rt);
    q0.push_back(expect_of(m0));
    q1.push_back(expect_of(m1));
    @(posedge clk_40MHz);
    #1;
    e = q0.pop_front();
    chk("x", xpos, e.x);
    chk("y", ypos, e.y);
    chk("air", airborne, e.air);
    chk("landed", landed, e.land);
    e = q1.pop_front();
    chk("c_x", c_xpos, e.x);
    chk("c_y", c_ypos, e.y);
    chk("c_air", c_airborne, e.air);
    chk("c_landed", c_landed, e.land);
  endtask

  task automatic pulse(input bit l, input bit rt);
    cyc(0, 0, 1, l, rt);
    cyc(0, 0, 0, l, rt);
  endtask

  // Tick continuously until the default instance is back on the ground.
  task automatic fly(input bit jr, input bit l, input bit rt, input int budget);
    int nl = 0;
    for (int i = 0; i < budget; i++) begin
      cyc(0, 1, jr, l, rt);
      if (landed) nl++;
      if (!airborne) break;
    end
    chk("land_pulses", nl, 1);
    chk("land_air", airborne, 0);
    chk("land_y", ypos, 500);
  endtask

  initial begin
    int nl;
    rst = 1'b1; movement_tick = 1'b0; jump_req = 1'b0; dir_left = 1'b0; dir_right = 1'b0;
    m0 = '{default: 0};
    m1 = '{default: 0};

    // Reset state
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    chk("rst_x", xpos, 380);
    chk("rst_y", ypos, 500);
    chk("rst_air", airborne, 0);
    chk("rst_landed", landed, 0);
    cyc(0, 0, 0, 0, 0);

    // Basic jump and ceiling/right edge on the small instance
    pulse(0, 0);
    cyc(0, 1, 0, 0, 1);
    chk("a_t1_y", ypos, 500);
    chk("a_t1_air", airborne, 1);
    chk("c_t1_x", c_xpos, 759);
    cyc(0, 1, 0, 0, 1);
    chk("a_t2_y", ypos, 488);
    chk("a_t2_x", xpos, 381);
    chk("c_t2_y", c_ypos, 8);
    chk("c_t2_x", c_xpos, 760);
    cyc(0, 1, 0, 0, 1);
    chk("a_t3_y", ypos, 476);
    chk("c_t3_y", c_ypos, 0);
    chk("c_t3_x", c_xpos, 760);
    chk("c_t3_air", c_airborne, 1);
    fly(0, 1, 1, 400);
    chk("a_x_both_hold", xpos, 382);

    // Request held high through landing: no re-jump until it falls and rises
    cyc(0, 0, 1, 0, 0);
    fly(1, 0, 0, 400);
    repeat (40) cyc(0, 1, 1, 0, 0);
    chk("b_no_rejump", airborne, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 1, 1, 0, 0);
    chk("b_rejump", airborne, 1);
    fly(0, 0, 0, 400);

    // Mid-air pulse ignored; ticks frozen for 1000 cycles mid-air
    pulse(1, 0);
    nl = 0;
    for (int i = 0; i < 400; i++) begin
      if (i == 10) pulse(1, 0);
      if (i == 20) begin
        snap = m0;
        repeat (1000) cyc(0, 0, 0, 1, 0);
        chk("frz_x", xpos, snap.x);
        chk("frz_y", ypos, snap.y);
        chk("frz_air", airborne, 1);
      end
      cyc(0, 1, 0, 1, 0);
      if (landed) nl++;
      if (!airborne) break;
    end
    chk("c_land_pulses", nl, 1);
    chk("c_land_y", ypos, 500);
    repeat (30) cyc(0, 1, 0, 1, 0);
    chk("c_pulse_ignored", airborne, 0);

    // Left steering into the floor
    for (int j = 0; j < 3; j++) begin
      pulse(1, 0);
      fly(0, 1, 0, 400);
    end
    chk("d_x_floor", xpos, 0);

    // Reset mid-rise
    pulse(0, 1);
    repeat (5) cyc(0, 1, 0, 0, 1);
    chk("e_pre_air", airborne, 1);
    cyc(1, 1, 0, 0, 1);
    chk("e_x", xpos, 380);
    chk("e_y", ypos, 500);
    chk("e_air", airborne, 0);
    chk("e_landed", landed, 0);
    chk("e_c_x", c_xpos, 759);
    cyc(0, 1, 0, 0, 0);
    chk("e_after_landed", landed, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/char_jump_ctrl.md
CHAR_JUMP_CTRL -- requirements
Module: char_jump_ctrl

Interface
REQ-001 Parameter X_START, default 12'd380, reset x position in pixels.
REQ-002 Parameter Y_GROUND, default 12'd500, ground y position in pixels; larger y is lower on screen.
REQ-003 Parameter JUMP_V0, default 6'd12, initial upward speed in pixels per tick.
REQ-004 Parameter V_MAX, default 6'd16, maximum falling speed in pixels per tick.
REQ-005 Parameter GRAV_DIV, default 4'd8, number of ticks per 1-pixel/tick speed change.
REQ-006 Parameter X_MAX, default 12'd760, rightmost legal x; leftmost legal x is 0.
REQ-007 clk_40MHz  in  1  system clock; rst  in  1  reset, synchronous, active-high.
REQ-008 movement_tick  in  1  one-cycle physics-step strobe from the movement timer.
REQ-009 jump_req  in  1  level jump request from the input decoder.
REQ-010 dir_left / dir_right  in  1 each  horizontal steering while airborne.
REQ-011 xpos, ypos  out  12 each  registered character position.
REQ-012 airborne  out  1  high in RISE or FALL state.
REQ-013 landed  out  1  one-cycle pulse on touchdown.

Function
REQ-014 FSM states are GROUND, RISE and FALL, and all state, position and speed updates occur only in cycles where movement_tick=1.
REQ-015 jump_req rising edges are detected every clock, and a rising edge in GROUND sets a pending flag; edges outside GROUND are discarded.
REQ-016 GROUND state, tick, pending=1 -> RISE, vel=JUMP_V0, grav_cnt=0, pending cleared; ypos is unchanged on this tick.
REQ-017 RISE state, each tick: if vel >= ypos then ypos=0 and go to FALL with vel=0; otherwise ypos -= vel.
REQ-018 RISE state, each tick: grav_cnt increments; when grav_cnt=GRAV_DIV-1, grav_cnt wraps to 0 and vel decrements; when vel reaches 0, go to FALL.
REQ-019 FALL state, each tick: if ypos+vel >= Y_GROUND then ypos=Y_GROUND, vel=0, state becomes GROUND, and landed=1 for the following single cycle; otherwise ypos += vel.
REQ-020 FALL state, each tick: grav_cnt increments and wraps as in REQ-018, and on wrap vel increments, saturating at V_MAX.
REQ-021 Horizontal motion applies only while airborne, once per tick: dir_left alone -> xpos-1, floored at 0; dir_right alone -> xpos+1, capped at X_MAX; both or neither -> hold.
REQ-022 Vertical arithmetic is 13-bit internally so that ypos+vel cannot wrap.
REQ-023 Outputs are registered; position changes become visible 1 cycle after the tick.
REQ-024 airborne is derived from the registered state.
REQ-025 Without movement_tick, all outputs hold indefinitely.

Reset
REQ-026 rst has priority over movement_tick.
REQ-027 Reset values: state GROUND, xpos=X_START, ypos=Y_GROUND, vel=0, grav_cnt=0, pending=0, airborne=0, landed=0.
REQ-028 A reset mid-jump returns the block to the reset values on the next edge, with no landed pulse.

Verification
REQ-029 Basic jump: jump_req pulse, then continuous ticks -> RISE; ypos sequence 500,488,476,...; apex after ceil-based velocity decay; returns to exactly 500 with one landed pulse.
REQ-030 Ceiling: Y_GROUND=20, JUMP_V0=12 -> second rise tick clamps ypos=0 and enters FALL.
REQ-031 Steering: dir_right held while airborne at xpos=759 -> xpos 760 and then holds; dir_left at xpos=0 -> stays 0; both held -> no change.
REQ-032 Request filtering: jump_req held high through landing -> no second jump until jump_req falls and rises again; a pulse while airborne -> ignored.
REQ-033 Tick gating: ticks stopped mid-air for 1000 cycles -> all outputs frozen; ticks resumed -> trajectory continues unchanged.
REQ-034 Reset: rst asserted mid-RISE -> next cycle xpos=380, ypos=500, airborne=0, landed=0.
